// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-controller bundle: pipeline stage info in, stall/flush/forward controls out.
// master = pipeline datapath side, slave = pipe_hazard_ctrl.
interface pipe_hazard_ctrl_if #(
   parameter int REG_AW = 5,
   parameter int CNT_W  = 16
);
   logic              id_valid;
   logic              id_uses_rs;
   logic              id_uses_rt;
   logic [REG_AW-1:0] id_rs;
   logic [REG_AW-1:0] id_rt;
   logic              ex_valid;
   logic              ex_regwr;
   logic              ex_load;
   logic [REG_AW-1:0] ex_dest;
   logic              mem_valid;
   logic              mem_regwr;
   logic [REG_AW-1:0] mem_dest;
   logic              wb_valid;
   logic              wb_regwr;
   logic [REG_AW-1:0] wb_dest;
   logic              ex_redirect;
   logic              stall_if;
   logic              bubble_ex;
   logic              flush;
   logic [1:0]        fwd_a;
   logic [1:0]        fwd_b;
   logic [CNT_W-1:0]  stall_cnt;
   logic [CNT_W-1:0]  flush_cnt;
   logic              state;

   modport master (
      output id_valid, id_uses_rs, id_uses_rt, id_rs, id_rt,
      output ex_valid, ex_regwr, ex_load, ex_dest,
      output mem_valid, mem_regwr, mem_dest,
      output wb_valid, wb_regwr, wb_dest, ex_redirect,
      input  stall_if, bubble_ex, flush, fwd_a, fwd_b,
      input  stall_cnt, flush_cnt, state
   );

   modport slave (
      input  id_valid, id_uses_rs, id_uses_rt, id_rs, id_rt,
      input  ex_valid, ex_regwr, ex_load, ex_dest,
      input  mem_valid, mem_regwr, mem_dest,
      input  wb_valid, wb_regwr, wb_dest, ex_redirect,
      output stall_if, bubble_ex, flush, fwd_a, fwd_b,
      output stall_cnt, flush_cnt, state
   );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: RAW detection, load-use stall, branch squash,
// stall/flush performance counters.
// Build option PIPE_HAZARD_FORWARD_EN: enables MEM/WB operand forwarding so
// only load-use hazards stall; without it every RAW hazard stalls.
//
// state    | meaning
// ST_RUN   | normal issue; a redirect flushes this cycle and may enter ST_FLUSH
// ST_FLUSH | squashing the remaining BRANCH_PENALTY-1 fetch slots
module pipe_hazard_ctrl #(
   parameter int REG_AW         = 5,
   parameter int CNT_W          = 16,
   parameter int BRANCH_PENALTY = 2
) (
   input  logic              clk,
   input  logic              reset_n,
   pipe_hazard_ctrl_if.slave hz
);

   typedef enum logic {ST_RUN = 1'b0, ST_FLUSH = 1'b1} state_t;

   localparam logic [2:0] PEN_LOAD = 3'(BRANCH_PENALTY - 1);

   state_t           state_q;
   logic [2:0]       pen_q;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

   logic [REG_AW-1:0] src_rs, src_rt;
   logic rd_rs, rd_rt;
   logic ex_wr, mem_wr, wb_wr;
   logic ex_rs, ex_rt, mem_rs, mem_rt, wb_rs, wb_rt;
   logic hazard, flush_w, stall_w;
   logic [1:0] fwd_a_w, fwd_b_w;

   assign src_rs = hz.id_rs;
   assign src_rt = hz.id_rt;
   assign rd_rs  = hz.id_valid & hz.id_uses_rs;
   assign rd_rt  = hz.id_valid & hz.id_uses_rt;

   // Writers targeting $0 are discarded here so $0 never matches anything.
   assign ex_wr  = hz.ex_valid  & hz.ex_regwr  & (hz.ex_dest  != '0);
   assign mem_wr = hz.mem_valid & hz.mem_regwr & (hz.mem_dest != '0);
   assign wb_wr  = hz.wb_valid  & hz.wb_regwr  & (hz.wb_dest  != '0);

   assign ex_rs  = rd_rs & ex_wr  & (hz.ex_dest  == src_rs);
   assign ex_rt  = rd_rt & ex_wr  & (hz.ex_dest  == src_rt);
   assign mem_rs = rd_rs & mem_wr & (hz.mem_dest == src_rs);
   assign mem_rt = rd_rt & mem_wr & (hz.mem_dest == src_rt);
   assign wb_rs  = rd_rs & wb_wr  & (hz.wb_dest  == src_rs);
   assign wb_rt  = rd_rt & wb_wr  & (hz.wb_dest  == src_rt);

`ifdef PIPE_HAZARD_FORWARD_EN
   // A load result is not available until after MEM, so only load-use must stall.
   assign hazard  = hz.ex_load & (ex_rs | ex_rt);
   assign fwd_a_w = mem_rs ? 2'b01 : (wb_rs ? 2'b10 : 2'b00);
   assign fwd_b_w = mem_rt ? 2'b01 : (wb_rt ? 2'b10 : 2'b00);
`else
   assign hazard  = ex_rs | ex_rt | mem_rs | mem_rt | wb_rs | wb_rt;
   assign fwd_a_w = 2'b00;
   assign fwd_b_w = 2'b00;
`endif

   // Squash beats stall: the stalled instruction is being thrown away anyway.
   assign flush_w = reset_n & ((state_q == ST_FLUSH) | hz.ex_redirect);
   assign stall_w = reset_n & ~flush_w & hazard;

   assign hz.flush     = flush_w;
   assign hz.stall_if  = stall_w;
   assign hz.bubble_ex = stall_w;
   assign hz.fwd_a     = reset_n ? fwd_a_w : 2'b00;
   assign hz.fwd_b     = reset_n ? fwd_b_w : 2'b00;
   assign hz.state     = (state_q == ST_FLUSH);
   assign hz.stall_cnt = stall_cnt_q;
   assign hz.flush_cnt = flush_cnt_q;

   // Saturating next-count for both performance counters.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (stall_w && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
      if (flush_w && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
   end

   // Branch-squash FSM; penalty counter counts down to terminal count 1.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= ST_RUN;
         pen_q   <= '0;
      end else begin
         case (state_q)
            ST_RUN: begin
               if (hz.ex_redirect && (BRANCH_PENALTY > 1)) begin
                  state_q <= ST_FLUSH;
                  pen_q   <= PEN_LOAD;
               end
            end
            ST_FLUSH: begin
               if (pen_q == 3'd1) begin
                  state_q <= ST_RUN;
                  pen_q   <= '0;
               end else begin
                  pen_q <= pen_q - 3'd1;
               end
            end
            default: begin
               state_q <= ST_RUN;
               pen_q   <= '0;
            end
         endcase
      end
   end

   // Performance counter registers.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl. dut0: defaults (CNT_W=16, BRANCH_PENALTY=2).
// dut1: CNT_W=4, BRANCH_PENALTY=3 for saturation and mid-flush reset.
module tb_pipe_hazard_ctrl;

`ifdef PIPE_HAZARD_FORWARD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   typedef struct packed {
      logic       id_valid;
      logic       uses_rs;
      logic       uses_rt;
      logic [4:0] rs;
      logic [4:0] rt;
      logic       ex_valid;
      logic       ex_regwr;
      logic       ex_load;
      logic [4:0] ex_dest;
      logic       mem_valid;
      logic       mem_regwr;
      logic [4:0] mem_dest;
      logic       wb_valid;
      logic       wb_regwr;
      logic [4:0] wb_dest;
      logic       redirect;
   } in_t;

   typedef struct packed {
      in_t        in;
      logic       sf;   // stall expected with forwarding
      logic [1:0] fa;   // fwd_a expected with forwarding
      logic [1:0] fb;   // fwd_b expected with forwarding
      logic       sn;   // stall expected without forwarding
   } vec_t;

   logic clk = 1'b0;
   logic rst0_n = 1'b0;
   logic rst1_n = 1'b0;
   in_t  in0 = '0;
   in_t  in1 = '0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   pipe_hazard_ctrl_if #(.REG_AW(5), .CNT_W(16)) hz0 ();
   pipe_hazard_ctrl_if #(.REG_AW(5), .CNT_W(4))  hz1 ();

   assign {hz0.id_valid, hz0.id_uses_rs, hz0.id_uses_rt, hz0.id_rs, hz0.id_rt,
           hz0.ex_valid, hz0.ex_regwr, hz0.ex_load, hz0.ex_dest,
           hz0.mem_valid, hz0.mem_regwr, hz0.mem_dest,
           hz0.wb_valid, hz0.wb_regwr, hz0.wb_dest, hz0.ex_redirect} = in0;
   assign {hz1.id_valid, hz1.id_uses_rs, hz1.id_uses_rt, hz1.id_rs, hz1.id_rt,
           hz1.ex_valid, hz1.ex_regwr, hz1.ex_load, hz1.ex_dest,
           hz1.mem_valid, hz1.mem_regwr, hz1.mem_dest,
           hz1.wb_valid, hz1.wb_regwr, hz1.wb_dest, hz1.ex_redirect} = in1;

   pipe_hazard_ctrl #(.REG_AW(5), .CNT_W(16), .BRANCH_PENALTY(2)) dut0 (
      .clk     (clk),
      .reset_n (rst0_n),
      .hz      (hz0)
   );

   pipe_hazard_ctrl #(.REG_AW(5), .CNT_W(4), .BRANCH_PENALTY(3)) dut1 (
      .clk     (clk),
      .reset_n (rst1_n),
      .hz      (hz1)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic in_t rd(logic urs, logic urt, logic [4:0] rs, logic [4:0] rt);
      in_t x = '0;
      x.id_valid = 1'b1;
      x.uses_rs  = urs;
      x.uses_rt  = urt;
      x.rs       = rs;
      x.rt       = rt;
      return x;
   endfunction

   function automatic in_t wex(in_t x_in, logic ld, logic [4:0] d);
      in_t x = x_in;
      x.ex_valid = 1'b1;
      x.ex_regwr = 1'b1;
      x.ex_load  = ld;
      x.ex_dest  = d;
      return x;
   endfunction

   function automatic in_t wmem(in_t x_in, logic [4:0] d);
      in_t x = x_in;
      x.mem_valid = 1'b1;
      x.mem_regwr = 1'b1;
      x.mem_dest  = d;
      return x;
   endfunction

   function automatic in_t wwb(in_t x_in, logic [4:0] d);
      in_t x = x_in;
      x.wb_valid = 1'b1;
      x.wb_regwr = 1'b1;
      x.wb_dest  = d;
      return x;
   endfunction

   function automatic vec_t vv(in_t x, logic sf, logic [1:0] fa, logic [1:0] fb, logic sn);
      vec_t v;
      v.in = x;
      v.sf = sf;
      v.fa = fa;
      v.fb = fb;
      v.sn = sn;
      return v;
   endfunction

   initial begin
      vec_t vecs[$];
      in_t  x;
      logic es;
      logic [1:0] efa, efb;
      int exp_sc = 0;
      int exp_fc = 0;

      // {inputs, stall(fwd), fwd_a, fwd_b, stall(no fwd)}
      vecs.push_back(vv('0, 1'b0, 2'd0, 2'd0, 1'b0));
      vecs.push_back(vv(wex(rd(1, 0, 5'd2, 5'd0), 1'b1, 5'd2), 1'b1, 2'd0, 2'd0, 1'b1));
      vecs.push_back(vv(wex(rd(1, 0, 5'd4, 5'd0), 1'b0, 5'd4), 1'b0, 2'd0, 2'd0, 1'b1));
      vecs.push_back(vv(wwb(wmem(rd(1, 0, 5'd3, 5'd0), 5'd3), 5'd3), 1'b0, 2'd1, 2'd0, 1'b1));
      vecs.push_back(vv(wwb(rd(1, 0, 5'd3, 5'd0), 5'd3), 1'b0, 2'd2, 2'd0, 1'b1));
      vecs.push_back(vv(wwb(wmem(wex(rd(1, 1, 5'd0, 5'd0), 1'b1, 5'd0), 5'd0), 5'd0),
                        1'b0, 2'd0, 2'd0, 1'b0));
      vecs.push_back(vv(wmem(rd(0, 1, 5'd7, 5'd7), 5'd7), 1'b0, 2'd0, 2'd1, 1'b1));
      x = wwb(wmem(wex(rd(1, 1, 5'd6, 5'd6), 1'b1, 5'd6), 5'd6), 5'd6);
      x.id_valid = 1'b0;
      vecs.push_back(vv(x, 1'b0, 2'd0, 2'd0, 1'b0));
      x = wmem(rd(1, 0, 5'd9, 5'd0), 5'd9);
      x.mem_regwr = 1'b0;
      vecs.push_back(vv(x, 1'b0, 2'd0, 2'd0, 1'b0));
      vecs.push_back(vv(wex(rd(0, 1, 5'd0, 5'd5), 1'b1, 5'd5), 1'b1, 2'd0, 2'd0, 1'b1));
      x = wex(rd(1, 0, 5'd5, 5'd0), 1'b1, 5'd5);
      x.ex_valid = 1'b0;
      vecs.push_back(vv(x, 1'b0, 2'd0, 2'd0, 1'b0));
      vecs.push_back(vv(wwb(wmem(rd(1, 1, 5'd8, 5'd9), 5'd8), 5'd9), 1'b0, 2'd1, 2'd2, 1'b1));
      vecs.push_back(vv(wwb(wex(rd(1, 0, 5'd10, 5'd0), 1'b1, 5'd10), 5'd10), 1'b1, 2'd2, 2'd0, 1'b1));
      vecs.push_back(vv(wmem(rd(1, 0, 5'd11, 5'd0), 5'd12), 1'b0, 2'd0, 2'd0, 1'b0));

      // Reset: hazard, forward source and redirect present, outputs must stay quiet.
      in0 = wmem(wex(rd(1, 1, 5'd2, 5'd3), 1'b1, 5'd2), 5'd3);
      in0.redirect = 1'b1;
      in1 = in0;
      step();
      step();
      chk("rst_stall", 32'(hz0.stall_if), 32'd0);
      chk("rst_bubble", 32'(hz0.bubble_ex), 32'd0);
      chk("rst_flush", 32'(hz0.flush), 32'd0);
      chk("rst_fwd_a", 32'(hz0.fwd_a), 32'd0);
      chk("rst_fwd_b", 32'(hz0.fwd_b), 32'd0);
      chk("rst_state", 32'(hz0.state), 32'd0);
      chk("rst_stall_cnt", 32'(hz0.stall_cnt), 32'd0);
      chk("rst_flush_cnt", 32'(hz0.flush_cnt), 32'd0);
      chk("rst1_flush", 32'(hz1.flush), 32'd0);
      in0 = '0;
      in1 = '0;
      rst0_n = 1'b1;
      rst1_n = 1'b1;
      step();

      // lw $2 in EX, add reads $2: one stall cycle, then the load sits in MEM.
      in0 = wex(rd(1, 0, 5'd2, 5'd0), 1'b1, 5'd2);
      #1;
      chk("lu_stall", 32'(hz0.stall_if), 32'd1);
      chk("lu_bubble", 32'(hz0.bubble_ex), 32'd1);
      chk("lu_cnt_before", 32'(hz0.stall_cnt), 32'd0);
      step();
      exp_sc = 1;
      in0 = wmem(rd(1, 0, 5'd2, 5'd0), 5'd2);
      #1;
      chk("lu_cnt_after", 32'(hz0.stall_cnt), 32'd1);
      chk("lu_next_stall", 32'(hz0.stall_if), FWD ? 32'd0 : 32'd1);
      chk("lu_next_fwd_a", 32'(hz0.fwd_a), FWD ? 32'd1 : 32'd0);
      step();
      exp_sc += FWD ? 0 : 1;
      in0 = '0;
      #1;
      chk("lu_cnt_final", 32'(hz0.stall_cnt), 32'(exp_sc));

      // Table-driven combinational checks; stall counter tracked alongside.
      foreach (vecs[i]) begin
         in0 = vecs[i].in;
         es  = FWD ? vecs[i].sf : vecs[i].sn;
         efa = FWD ? vecs[i].fa : 2'd0;
         efb = FWD ? vecs[i].fb : 2'd0;
         #1;
         chk($sformatf("vec%0d_stall", i), 32'(hz0.stall_if), 32'(es));
         chk($sformatf("vec%0d_bubble", i), 32'(hz0.bubble_ex), 32'(es));
         chk($sformatf("vec%0d_flush", i), 32'(hz0.flush), 32'd0);
         chk($sformatf("vec%0d_fwd_a", i), 32'(hz0.fwd_a), 32'(efa));
         chk($sformatf("vec%0d_fwd_b", i), 32'(hz0.fwd_b), 32'(efb));
         step();
         exp_sc += int'(es);
         chk($sformatf("vec%0d_stall_cnt", i), 32'(hz0.stall_cnt), 32'(exp_sc));
      end
      in0 = '0;
      step();

      // Redirect pulse, penalty 2: flush two cycles, state 0,1,0.
      in0.redirect = 1'b1;
      #1;
      chk("br_flush0", 32'(hz0.flush), 32'd1);
      chk("br_state0", 32'(hz0.state), 32'd0);
      step();
      in0.redirect = 1'b0;
      #1;
      chk("br_flush1", 32'(hz0.flush), 32'd1);
      chk("br_state1", 32'(hz0.state), 32'd1);
      step();
      exp_fc = 2;
      chk("br_flush2", 32'(hz0.flush), 32'd0);
      chk("br_state2", 32'(hz0.state), 32'd0);
      chk("br_flush_cnt", 32'(hz0.flush_cnt), 32'(exp_fc));

      // Redirect with load-use; redirect held into FLUSH is ignored.
      in0 = wex(rd(1, 0, 5'd2, 5'd0), 1'b1, 5'd2);
      in0.redirect = 1'b1;
      #1;
      chk("prio_flush", 32'(hz0.flush), 32'd1);
      chk("prio_stall", 32'(hz0.stall_if), 32'd0);
      chk("prio_bubble", 32'(hz0.bubble_ex), 32'd0);
      step();
      chk("prio_state1", 32'(hz0.state), 32'd1);
      chk("prio_flush1", 32'(hz0.flush), 32'd1);
      chk("prio_stall1", 32'(hz0.stall_if), 32'd0);
      chk("prio_stall_cnt1", 32'(hz0.stall_cnt), 32'(exp_sc));
      step();
      exp_fc += 2;
      in0 = '0;
      #1;
      chk("prio_state2", 32'(hz0.state), 32'd0);
      chk("prio_flush2", 32'(hz0.flush), 32'd0);
      chk("prio_stall_cnt2", 32'(hz0.stall_cnt), 32'(exp_sc));
      chk("prio_flush_cnt", 32'(hz0.flush_cnt), 32'(exp_fc));

      // dut1: penalty 3 gives three flush cycles.
      in1.redirect = 1'b1;
      #1;
      chk("bp3_flush0", 32'(hz1.flush), 32'd1);
      step();
      in1.redirect = 1'b0;
      #1;
      chk("bp3_state1", 32'(hz1.state), 32'd1);
      step();
      chk("bp3_state2", 32'(hz1.state), 32'd1);
      chk("bp3_flush2", 32'(hz1.flush), 32'd1);
      step();
      chk("bp3_state3", 32'(hz1.state), 32'd0);
      chk("bp3_flush3", 32'(hz1.flush), 32'd0);
      chk("bp3_flush_cnt", 32'(hz1.flush_cnt), 32'd3);

      // dut1: 20 separate load-use stalls saturate a 4-bit counter at 15.
      for (int n = 0; n < 20; n++) begin
         in1 = wex(rd(1, 0, 5'd2, 5'd0), 1'b1, 5'd2);
         step();
         in1 = '0;
         step();
         if (n == 13) chk("sat_cnt14", 32'(hz1.stall_cnt), 32'd14);
      end
      chk("sat_cnt", 32'(hz1.stall_cnt), 32'd15);
      chk("sat_fwd_a", 32'(hz1.fwd_a), 32'd0);

      // dut1: reset during second flush cycle aborts the flush.
      in1.redirect = 1'b1;
      step();
      in1.redirect = 1'b0;
      #1;
      chk("mrst_state_pre", 32'(hz1.state), 32'd1);
      rst1_n = 1'b0;
      #1;
      chk("mrst_flush_in_rst", 32'(hz1.flush), 32'd0);
      chk("mrst_bubble_in_rst", 32'(hz1.bubble_ex), 32'd0);
      step();
      rst1_n = 1'b1;
      #1;
      chk("mrst_state", 32'(hz1.state), 32'd0);
      chk("mrst_flush", 32'(hz1.flush), 32'd0);
      chk("mrst_stall_cnt", 32'(hz1.stall_cnt), 32'd0);
      chk("mrst_flush_cnt", 32'(hz1.flush_cnt), 32'd0);
      step();
      chk("mrst_state_after", 32'(hz1.state), 32'd0);
      chk("mrst_stall_after", 32'(hz1.stall_if), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter REG_AW, default 5, register-address width.
REQ-002 SHALL have parameter CNT_W, default 16, width of each performance counter.
REQ-003 SHALL have parameter BRANCH_PENALTY, default 2 (legal 1..7), number of fetch slots squashed per taken control transfer.
REQ-004 SHALL have port clk  in  1  sole clock; all state changes on rising edge.
REQ-005 SHALL have port reset_n  in  1  synchronous, active-low reset.
REQ-006 SHALL have ports id_valid, id_uses_rs, id_uses_rt  in  1 each  RF-stage instruction valid; reads rs; reads rt.
REQ-007 SHALL have ports id_rs, id_rt  in  REG_AW each  RF-stage source register addresses.
REQ-008 SHALL have ports ex_valid, ex_regwr, ex_load  in  1 each, and ex_dest  in  REG_AW  EX-stage writer info.
REQ-009 SHALL have ports mem_valid, mem_regwr  in  1 each, and mem_dest  in  REG_AW  MEM-stage writer info.
REQ-010 SHALL have ports wb_valid, wb_regwr  in  1 each, and wb_dest  in  REG_AW  WB-stage writer info.
REQ-011 SHALL have port ex_redirect  in  1  EX resolved a taken BEQ/BNE, J, JAL or JR.
REQ-012 SHALL have ports stall_if  out  1 (hold PC and IF/RF register) and bubble_ex  out  1 (load NOP into RF/EX register).
REQ-013 SHALL have port flush  out  1  replace IF/RF contents with NOP.
REQ-014 SHALL have ports fwd_a, fwd_b  out  2 each  operand select: 00 regfile, 01 MEM-stage ALU result, 10 WB value.
REQ-015 SHALL have ports stall_cnt, flush_cnt  out  CNT_W each, and state  out  1 (0 RUN, 1 FLUSH).

Function
REQ-016 A source "matches" stage X iff X_valid & X_regwr & X_dest!=0 & X_dest equals that source & the matching id_uses_* is 1 & id_valid is 1.
REQ-017 Register 0 SHALL never produce a match, stall or forward.
REQ-018 State RUN: ex_redirect=1 SHALL assert flush in the same cycle and, if BRANCH_PENALTY>1, move to FLUSH with penalty counter = BRANCH_PENALTY-1.
REQ-019 State FLUSH: flush=1 every cycle; penalty counter decrements; at counter 1 -> RUN next edge; ex_redirect ignored.
REQ-020 Flush SHALL take priority: whenever flush=1, stall_if=0 and bubble_ex=0.
REQ-021 Load-use (ex_load & EX match) SHALL assert stall_if=1 and bubble_ex=1 for exactly one cycle per load.
REQ-022 stall_cnt SHALL increment once per cycle with stall_if=1; flush_cnt once per cycle with flush=1; both saturate at all-ones, no wrap.
REQ-023 Outputs stall_if, bubble_ex, flush, fwd_* SHALL be combinational from inputs and state; counters and state registered.

Reset
REQ-024 reset_n=0 at a clock edge SHALL set state=RUN, penalty counter=0, stall_cnt=0, flush_cnt=0.
REQ-025 While reset_n=0, stall_if, bubble_ex and flush SHALL be 0 and fwd_a=fwd_b=00.
REQ-026 Reset asserted mid-FLUSH SHALL abort the flush; first cycle after release is RUN.

Configuration
REQ-027 Macro PIPE_HAZARD_FORWARD_EN defined: fwd_* select 01 on MEM match, else 10 on WB match, else 00; MEM beats WB; only load-use stalls.
REQ-028 Macro undefined: fwd_a=fwd_b=00 always; any EX, MEM or WB match stalls (stall_if=1, bubble_ex=1), repeating until no match.

Verification
REQ-029 lw $2 in EX, RF add reads $2 -> exactly one cycle stall_if=1,bubble_ex=1; stall_cnt 0->1.
REQ-030 FORWARD_EN: MEM dest=$3 and WB dest=$3, RF reads rs=$3 -> fwd_a=01; WB only -> fwd_a=10; dest=$0 -> 00.
REQ-031 BRANCH_PENALTY=2, ex_redirect pulse in RUN -> flush=1 for 2 cycles, state 0,1,0; flush_cnt +2.
REQ-032 ex_redirect with simultaneous load-use -> flush=1, stall_if=0, bubble_ex=0, stall_cnt unchanged.
REQ-033 CNT_W=4, 20 load-use stalls -> stall_cnt holds 15.
REQ-034 reset_n low during second flush cycle of BRANCH_PENALTY=3 -> next cycle state=0, flush=0, counters 0.
